// File: rtl/leg_solver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leg_solver_pkg
//  Description : Shared types and constants for the leg solver and its
//                bit-serial square-root engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package leg_solver_pkg;

    localparam int c_width_def = 8;
    localparam int c_cnt_w     = $clog2(c_width_def);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        DIFF   = 2'd2,
        SQRT   = 2'd3
    } state_t;

    // Counter width for an arbitrary WIDTH, kept at least one bit wide.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Bit-serial restoring integer square root, one root bit per
//                step, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [2*WIDTH-1:0]   value,
    input  logic                 step,
    output logic [WIDTH-1:0]     root
);

    localparam int c_rem_w = 2*WIDTH + 2;

    logic [c_rem_w-1:0]  r_rem;
    logic [2*WIDTH-1:0]  r_val;
    logic [WIDTH-1:0]    r_root;

    logic [c_rem_w-1:0]  w_rem_sh;
    logic [c_rem_w-1:0]  w_trial;
    logic                w_ge;

    // Bring down the next radicand bit pair and try appending a 1 to the root.
    assign w_rem_sh = (r_rem << 2) | c_rem_w'(r_val[2*WIDTH-1 -: 2]);
    assign w_trial  = {{WIDTH{1'b0}}, r_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);

    // Root with the bit of the step in progress already resolved, so the
    // caller can capture the final result on the last step edge.
    assign root = {r_root[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_val  <= '0;
            r_root <= '0;
        end else if (load) begin
            r_rem  <= '0;
            r_val  <= value;
            r_root <= '0;
        end else if (step) begin
            r_rem  <= w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
            r_val  <= {r_val[2*WIDTH-3:0], 2'b00};
            r_root <= root;
        end
    end

endmodule
`default_nettype wire

// File: rtl/leg_solver.sv
`default_nettype none
// ============================================================================
//  Module      : leg_solver
//  Description : Sequential y = floor(sqrt(r^2 - x^2)) using shift-add
//                squaring and a bit-serial square root.
//  Revision    : 1.0 - initial release
// ============================================================================
module leg_solver
    import leg_solver_pkg::*;
#(
    parameter int WIDTH = c_width_def
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] x_in,
    output logic [WIDTH-1:0] y_out,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int                 c_cw   = cnt_width(WIDTH);
    localparam logic [c_cw-1:0]    c_last = c_cw'(WIDTH - 1);

    state_t              r_state;
    logic [WIDTH-1:0]    r_r;
    logic [WIDTH-1:0]    r_x;
    logic [2*WIDTH-1:0]  r_r_sq;
    logic [2*WIDTH-1:0]  r_x_sq;
    logic [c_cw-1:0]     r_cnt;
    logic                r_err_pend;

    logic                w_x_gt_r;
    logic [2*WIDTH-1:0]  w_diff;
    logic                w_load;
    logic                w_step;
    logic [WIDTH-1:0]    w_root;

    // x > r would make the difference negative; the root then runs on zero.
    assign w_x_gt_r = (r_x > r_r);
    assign w_diff   = w_x_gt_r ? '0 : (r_r_sq - r_x_sq);
    assign w_load   = ena && (r_state == DIFF);
    assign w_step   = ena && (r_state == SQRT);

    isqrt_seq #(
        .WIDTH (WIDTH)
    ) u_isqrt (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .value (w_diff),
        .step  (w_step),
        .root  (w_root)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_r        <= '0;
            r_x        <= '0;
            r_r_sq     <= '0;
            r_x_sq     <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            y_out      <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_r        <= r_in;
                        r_x        <= x_in;
                        r_r_sq     <= '0;
                        r_x_sq     <= '0;
                        r_cnt      <= '0;
                        r_err_pend <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= SQUARE;
                    end
                end
                SQUARE: begin
                    if (r_r[r_cnt])
                        r_r_sq <= r_r_sq + ({{WIDTH{1'b0}}, r_r} << r_cnt);
                    if (r_x[r_cnt])
                        r_x_sq <= r_x_sq + ({{WIDTH{1'b0}}, r_x} << r_cnt);
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_state <= DIFF;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DIFF: begin
                    r_err_pend <= w_x_gt_r;
                    r_state    <= SQRT;
                end
                SQRT: begin
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        y_out   <= r_err_pend ? '0 : w_root;
                        err     <= r_err_pend;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leg_solver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leg_solver
//  Description : Scoreboard bench for leg_solver: directed vectors plus a
//                random sweep against a floor-sqrt model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leg_solver;

    typedef struct {
        int y;
        int e;
        int acc;
        int lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [7:0] r_in = '0;
    logic [7:0] x_in = '0;
    logic [7:0] y_out;
    logic       err;
    logic       busy;
    logic       done;

    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    leg_solver #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .start (start),
        .r_in  (r_in),
        .x_in  (x_in),
        .y_out (y_out),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int isqrt_ref(input int v);
        int y = 0;
        while ((y + 1) * (y + 1) <= v) y++;
        return y;
    endfunction

    // Monitor: every done pops one expectation and checks data and latency.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got y=%0d err=%0d, expected no done", y_out, err);
            end else begin
                e = sb.pop_front();
                chk("y_out", int'(y_out), e.y);
                chk("err", int'(err), e.e);
                chk("latency", cyc - e.acc, e.lat);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Caller is at a negedge; returns #1 after the accept edge.
    task automatic issue(input int r, input int x, input int ey, input int ee, input int stall);
        exp_t e;
        r_in  = 8'(r);
        x_in  = 8'(x);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.y   = ey;
        e.e   = ee;
        e.acc = cyc;
        e.lat = 17 + stall;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", n);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done_cycle();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_wait_timeout: got done=0 after %0d cycles, expected 1", n);
        end
    endtask

    initial begin
        int busy_n;
        int dc;
        int r;
        int x;

        repeat (3) @(negedge clk);
        chk("reset_y_out", int'(y_out), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic op with busy-duration measurement.
        issue(5, 3, 4, 0, 0);
        busy_n = 0;
        repeat (17) begin
            @(negedge clk);
            if (busy) busy_n++;
        end
        chk("busy_cycles", busy_n, 17);
        @(negedge clk);
        chk("busy_after_done", int'(busy), 0);
        wait_idle();

        issue(100, 37, 92, 0, 0);  wait_idle();
        issue(255, 0, 255, 0, 0);  wait_idle();
        issue(10, 10, 0, 0, 0);    wait_idle();
        issue(3, 5, 0, 1, 0);      wait_idle();
        issue(255, 255, 0, 0, 0);  wait_idle();
        issue(255, 254, 22, 0, 0); wait_idle();
        issue(1, 0, 1, 0, 0);      wait_idle();
        issue(0, 1, 0, 1, 0);      wait_idle();

        // Stall five edges mid-SQRT, plus an ignored start while busy.
        dc = done_cnt;
        issue(5, 4, 3, 0, 5);
        repeat (3) @(negedge clk);
        r_in = 8'd1; x_in = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        ena = 1'b0;
        repeat (5) @(negedge clk);
        ena = 1'b1;
        wait_idle();
        repeat (20) @(negedge clk);
        chk("single_done_count", done_cnt - dc, 1);

        // Start accepted in the done cycle.
        issue(13, 5, 12, 0, 0);
        wait_done_cycle();
        issue(25, 7, 24, 0, 0);
        wait_idle();

        // Asynchronous reset during SQUARE aborts with no done.
        dc = done_cnt;
        @(negedge clk);
        r_in = 8'd200; x_in = 8'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_y_out", int'(y_out), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_cnt - dc, 0);
        issue(13, 5, 12, 0, 0);
        wait_idle();

        // Random sweep against the model.
        repeat (60) begin
            r = int'($urandom_range(0, 255));
            x = int'($urandom_range(0, r));
            issue(r, x, isqrt_ref(r * r - x * x), 0, 0);
            wait_idle();
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
